crc_frame_link: RTL and testbench
=================================

CRC_FRAME_LINK -- requirements
Module: crc_frame_link

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, range 2..32.
REQ-002 Parameter CRC_W, default 3: CRC width in bits, range 2..16, less than DATA_W.
REQ-003 Parameter POLY, default 3'b011: generator polynomial low CRC_W coefficients; default is x^3+x+1 with the implicit x^CRC_W term.
REQ-004 Port GCLK, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port CLEAR_BAR, input, 1: reset, asynchronous and active-low.
REQ-006 Port Din, input, DATA_W: parallel payload.
REQ-007 Port Load, input, 1: start-frame request.
REQ-008 Port Busy, output, 1: transmitter is occupied.
REQ-009 Port Serial_Out, output, 1: transmit bit stream.
REQ-010 Port Tx_Valid, output, 1: Serial_Out carries a frame bit this cycle.
REQ-011 Port Serial_In, input, 1: receive bit stream.
REQ-012 Port Rx_Valid, input, 1: Serial_In carries a frame bit this cycle.
REQ-013 Port Rx_Data, output, DATA_W: last received payload.
REQ-014 Port Done, output, 1: one-cycle frame-complete strobe.
REQ-015 Port ERROR, output, 1: CRC check result of the last complete frame.
REQ-016 Port Err_Count, output, 8: count of failed frames, saturating.

Function
REQ-017 Transmit FSM SHALL have three states: IDLE, DATA and CRC.
REQ-018 In IDLE, when Load=1 is sampled, the FSM SHALL capture Din, clear the CRC register to 0 and go to DATA; in every other state Load SHALL be ignored.
REQ-019 DATA state: SHALL drive the payload MSB-first for DATA_W cycles.
REQ-020 CRC state: SHALL drive CRC bits MSB-first for CRC_W cycles, then return to IDLE.
REQ-021 Transmit CRC update for each payload bit b SHALL be: fb = b XOR crc[MSB]; crc = (crc << 1) XOR (fb ? POLY : 0).
REQ-022 Tx_Valid SHALL be 1 exactly in DATA and CRC states.
REQ-023 Busy SHALL be 1 from the cycle after Load is accepted through the last CRC bit.
REQ-024 Minimum spacing between frames SHALL be one IDLE cycle.
REQ-025 In IDLE, Serial_Out SHALL be 0.
REQ-026 The receiver SHALL process Serial_In only in cycles where Rx_Valid=1.
REQ-027 For each valid receive bit b, the division register SHALL update as: rem = ({rem[CRC_W-2:0], b}) XOR (rem[MSB] ? POLY : 0).
REQ-028 The receive bit counter SHALL run from 0 to DATA_W+CRC_W-1.
REQ-029 The first DATA_W received bits SHALL shift MSB-first into a staging register.
REQ-030 On the final valid bit, the cycle after it SHALL update all of the following together:
  - Done=1 for exactly one cycle;
  - Rx_Data = staging register;
  - ERROR = (final remainder != 0), held until the next Done;
  - Err_Count incremented if ERROR=1, saturating at 255.
REQ-031 When Rx_Valid drops to 0 with the bit counter nonzero, the frame SHALL abort:
  - counter and remainder cleared;
  - no Done strobe;
  - ERROR, Rx_Data and Err_Count unchanged.
REQ-032 A receive frame SHALL start with the remainder at 0.
REQ-033 A valid bit SHALL be accepted on the cycle immediately after the previous frame's last bit, starting a new frame.
REQ-034 Transmitter and receiver SHALL be independent; simultaneous transmit and receive SHALL be supported.

Reset
REQ-035 While CLEAR_BAR=0, regardless of clock, the block SHALL hold all of the following:
  - FSM in IDLE;
  - Busy, Tx_Valid, Serial_Out, Done and ERROR = 0;
  - Rx_Data = 0, Err_Count = 0;
  - all counters, CRC and remainder registers = 0.
REQ-036 Reset asserted mid-frame SHALL discard the frame with no Done; after release, the next Load SHALL transmit a complete, correct frame.

Verification (DATA_W=8, CRC_W=3, POLY=011; loopback Serial_Out->Serial_In, Tx_Valid->Rx_Valid unless noted)
REQ-037 Load with Din=8'hA5 -> Serial_Out sequence is 1,0,1,0,0,1,0,1,1,0,1 over 11 Tx_Valid cycles, Done strobes, Rx_Data=8'hA5, ERROR=0, Err_Count=0.
REQ-038 As REQ-037, with the 4th transmitted bit inverted in the loopback path -> Done strobes, ERROR=1, Err_Count=1, Rx_Data=8'hB5.
REQ-039 Load pulsed again while Busy=1 -> request ignored; exactly one 11-bit frame is sent; the next Load after Busy falls sends 8'h3C correctly.
REQ-040 Rx_Valid forced to 0 after 5 received bits -> no Done; ERROR and Rx_Data keep prior values; the following full frame checks correctly.
REQ-041 300 corrupted frames -> Err_Count=255 and holds; one clean frame then gives ERROR=0 with Err_Count still 255.
REQ-042 CLEAR_BAR pulsed low mid-CRC state -> all outputs 0 immediately (asynchronous); a subsequent Load 8'h00 gives Serial_Out all zeros and ERROR=0.

Source files
------------

// File: rtl/crc_frame_link.sv
// Serial frame link: a transmitter that sends a payload followed by its CRC, and an
// independent receiver that re-divides the incoming stream and reports frame status.
module crc_frame_link #(
  parameter int                DATA_W = 8,
  parameter int                CRC_W  = 3,
  parameter logic [CRC_W-1:0]  POLY   = CRC_W'(3'b011)
) (
  input  logic              GCLK,
  input  logic              CLEAR_BAR,
  input  logic [DATA_W-1:0] Din,
  input  logic              Load,
  output logic              Busy,
  output logic              Serial_Out,
  output logic              Tx_Valid,
  input  logic              Serial_In,
  input  logic              Rx_Valid,
  output logic [DATA_W-1:0] Rx_Data,
  output logic              Done,
  output logic              ERROR,
  output logic [7:0]        Err_Count
);

  localparam int FRAME_N = DATA_W + CRC_W;
  localparam int CNT_W   = $clog2(FRAME_N);

  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(CRC_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } tx_state_e;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [CRC_W-1:0]  tx_crc_q, tx_crc_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_fb;

  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CRC_W-1:0]  rx_rem_q, rx_rem_d;
  logic [CRC_W-1:0]  rx_rem_next;
  logic [DATA_W-1:0] rx_stage_q, rx_stage_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        err_count_q, err_count_d;

  // Transmit sequencing: payload bits feed the CRC LFSR while they are sent,
  // then the finished CRC register is shifted out as-is.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    tx_crc_d   = tx_crc_q;
    tx_cnt_d   = tx_cnt_q;
    tx_fb      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Load) begin
          state_d    = DATA;
          tx_shift_d = Din;
          tx_crc_d   = '0;
          tx_cnt_d   = '0;
        end
      end
      DATA: begin
        tx_fb      = tx_shift_q[DATA_W-1] ^ tx_crc_q[CRC_W-1];
        tx_crc_d   = {tx_crc_q[CRC_W-2:0], 1'b0} ^ (tx_fb ? POLY : '0);
        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        if (tx_cnt_q == DATA_LAST) begin
          state_d  = CRC;
          tx_cnt_d = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      CRC: begin
        tx_crc_d = {tx_crc_q[CRC_W-2:0], 1'b0};
        if (tx_cnt_q == CRC_LAST) begin
          state_d  = IDLE;
          tx_cnt_d = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge GCLK or negedge CLEAR_BAR) begin
    if (!CLEAR_BAR) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      tx_crc_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      tx_crc_q   <= tx_crc_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign Tx_Valid = (state_q == DATA) || (state_q == CRC);
  assign Busy     = Tx_Valid;

  always_comb begin
    case (state_q)
      DATA:    Serial_Out = tx_shift_q[DATA_W-1];
      CRC:     Serial_Out = tx_crc_q[CRC_W-1];
      default: Serial_Out = 1'b0;
    endcase
  end

  // Receive division: a valid codeword leaves a zero remainder after all
  // FRAME_N bits. A gap in Rx_Valid mid-frame throws the partial frame away.
  always_comb begin
    rx_cnt_d    = rx_cnt_q;
    rx_rem_d    = rx_rem_q;
    rx_stage_d  = rx_stage_q;
    rx_data_d   = rx_data_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_count_d = err_count_q;
    rx_rem_next = {rx_rem_q[CRC_W-2:0], Serial_In} ^ (rx_rem_q[CRC_W-1] ? POLY : '0);
    if (Rx_Valid) begin
      if (rx_cnt_q <= DATA_LAST) begin
        rx_stage_d = {rx_stage_q[DATA_W-2:0], Serial_In};
      end
      if (rx_cnt_q == FRAME_LAST) begin
        done_d    = 1'b1;
        rx_data_d = rx_stage_q;
        error_d   = |rx_rem_next;
        if ((|rx_rem_next) && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
        rx_cnt_d = '0;
        rx_rem_d = '0;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_rem_d = rx_rem_next;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = '0;
      rx_rem_d = '0;
    end
  end

  always_ff @(posedge GCLK or negedge CLEAR_BAR) begin
    if (!CLEAR_BAR) begin
      rx_cnt_q    <= '0;
      rx_rem_q    <= '0;
      rx_stage_q  <= '0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      rx_cnt_q    <= rx_cnt_d;
      rx_rem_q    <= rx_rem_d;
      rx_stage_q  <= rx_stage_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  assign Rx_Data   = rx_data_q;
  assign Done      = done_q;
  assign ERROR     = error_q;
  assign Err_Count = err_count_q;

endmodule

// File: tb/tb_crc_frame_link.sv
// Loopback bench for crc_frame_link: expected frames come from polynomial long division,
// a negedge monitor checks the serial stream and receive results against scoreboards.
`timescale 1ns/1ps
module tb_crc_frame_link;

  localparam int               DATA_W  = 8;
  localparam int               CRC_W   = 3;
  localparam logic [CRC_W-1:0] POLY    = 3'b011;
  localparam int               FRAME_N = DATA_W + CRC_W;
  localparam int               GEN     = (1 << CRC_W) | int'(POLY);

  logic              GCLK = 1'b0;
  logic              CLEAR_BAR = 1'b1;
  logic [DATA_W-1:0] Din = '0;
  logic              Load = 1'b0;
  logic              Busy;
  logic              Serial_Out;
  logic              Tx_Valid;
  logic              Serial_In;
  logic              Rx_Valid;
  logic [DATA_W-1:0] Rx_Data;
  logic              Done;
  logic              ERROR;
  logic [7:0]        Err_Count;

  logic flip_now = 1'b0;
  logic rx_gate  = 1'b0;

  // Loopback path with optional single-bit corruption and receive-valid gating
  assign Serial_In = Serial_Out ^ flip_now;
  assign Rx_Valid  = Tx_Valid & ~rx_gate;

  crc_frame_link #(.DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(POLY)) dut (
    .GCLK       (GCLK),
    .CLEAR_BAR  (CLEAR_BAR),
    .Din        (Din),
    .Load       (Load),
    .Busy       (Busy),
    .Serial_Out (Serial_Out),
    .Tx_Valid   (Tx_Valid),
    .Serial_In  (Serial_In),
    .Rx_Valid   (Rx_Valid),
    .Rx_Data    (Rx_Data),
    .Done       (Done),
    .ERROR      (ERROR),
    .Err_Count  (Err_Count)
  );

  always #5 GCLK = ~GCLK;

  typedef struct {
    int data;
    int err;
    int cnt;
  } rx_exp_t;

  int      txq[$];
  rx_exp_t rxq[$];
  int      checks = 0;
  int      errors = 0;
  int      held_data = 0;
  int      held_err = 0;
  int      held_cnt = 0;
  int      err_model = 0;
  int      cur_flip = -1;
  int      cur_abort = -1;

  function automatic int poly_mod(input int val, input int nbits);
    int v;
    v = val;
    for (int i = nbits - 1; i >= CRC_W; i--) begin
      if (v[i]) v = v ^ (GEN << (i - CRC_W));
    end
    return v;
  endfunction

  function automatic int codeword(input int data);
    int shifted;
    shifted = data << CRC_W;
    return shifted | poly_mod(shifted, FRAME_N);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Leaves the caller just after a rising edge with the transmitter idle
  task automatic waitTxIdle();
    int k;
    k = 0;
    @(posedge GCLK); #1;
    while (txq.size() != 0 && k < 200) begin
      @(posedge GCLK); #1;
      k++;
    end
    if (txq.size() != 0) begin
      checkOutput("tx_idle_timeout", txq.size(), 0);
      txq.delete();
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge GCLK);
    #1;
  endtask

  task automatic applyStimulus(input int data, input int flip_idx, input int abort_idx,
                               input int cw_fixed);
    int cw;
    int rw;
    rx_exp_t e;
    waitTxIdle();
    Din  = DATA_W'(data);
    Load = 1'b1;
    @(posedge GCLK); #1;
    Load = 1'b0;
    cw = (cw_fixed >= 0) ? cw_fixed : codeword(data);
    for (int i = FRAME_N - 1; i >= 0; i--) txq.push_back((cw >> i) & 1);
    cur_flip  = flip_idx;
    cur_abort = abort_idx;
    if (abort_idx < 0) begin
      rw = cw;
      if (flip_idx >= 0) rw = rw ^ (1 << (FRAME_N - 1 - flip_idx));
      e.data = rw >> CRC_W;
      e.err  = (poly_mod(rw, FRAME_N) != 0) ? 1 : 0;
      if (e.err == 1 && err_model < 255) err_model++;
      e.cnt = err_model;
      rxq.push_back(e);
    end
  endtask

  task automatic pulseLoadBusy(input int data);
    Din  = DATA_W'(data);
    Load = 1'b1;
    @(posedge GCLK); #1;
    Load = 1'b0;
  endtask

  // Monitor: serial stream versus tx scoreboard, receive outputs versus rx scoreboard
  always @(negedge GCLK) begin
    int idx;
    int bit_exp;
    rx_exp_t e;
    checkOutput("busy", int'(Busy), (txq.size() > 0) ? 1 : 0);
    checkOutput("tx_valid", int'(Tx_Valid), (txq.size() > 0) ? 1 : 0);
    if (txq.size() > 0) begin
      idx     = FRAME_N - txq.size();
      bit_exp = txq.pop_front();
      checkOutput("serial_out", int'(Serial_Out), bit_exp);
      flip_now = (idx == cur_flip);
      rx_gate  = (cur_abort >= 0) && (idx >= cur_abort);
    end else begin
      checkOutput("serial_out_idle", int'(Serial_Out), 0);
      flip_now = 1'b0;
      rx_gate  = 1'b0;
    end
    if (Done) begin
      if (rxq.size() == 0) begin
        checkOutput("done_unexpected", int'(Done), 0);
      end else begin
        e = rxq.pop_front();
        held_data = e.data;
        held_err  = e.err;
        held_cnt  = e.cnt;
      end
    end
    checkOutput("rx_data", int'(Rx_Data), held_data);
    checkOutput("error", int'(ERROR), held_err);
    checkOutput("err_count", int'(Err_Count), held_cnt);
  end

  initial begin
    int k;
    #1 CLEAR_BAR = 1'b0;
    #2;
    checkOutput("rst_busy", int'(Busy), 0);
    checkOutput("rst_tx_valid", int'(Tx_Valid), 0);
    checkOutput("rst_serial_out", int'(Serial_Out), 0);
    checkOutput("rst_done", int'(Done), 0);
    checkOutput("rst_error", int'(ERROR), 0);
    checkOutput("rst_rx_data", int'(Rx_Data), 0);
    checkOutput("rst_err_count", int'(Err_Count), 0);
    repeat (2) @(posedge GCLK);
    #2 CLEAR_BAR = 1'b1;

    // Clean A5 frame with its known serial pattern
    applyStimulus(8'hA5, -1, -1, 11'b10100101101);
    waitTxIdle(); settle();
    checkOutput("a5_rx_data", int'(Rx_Data), 8'hA5);
    checkOutput("a5_error", int'(ERROR), 0);
    checkOutput("a5_err_count", int'(Err_Count), 0);

    // Fourth bit inverted in flight
    applyStimulus(8'hA5, 3, -1, -1);
    waitTxIdle(); settle();
    checkOutput("a5_flip_rx_data", int'(Rx_Data), 8'hB5);
    checkOutput("a5_flip_error", int'(ERROR), 1);
    checkOutput("a5_flip_err_count", int'(Err_Count), 1);

    // Load pulses during a frame are ignored, then 3C follows
    applyStimulus(8'h5A, -1, -1, -1);
    pulseLoadBusy(8'hFF);
    repeat (4) @(posedge GCLK); #1;
    pulseLoadBusy(8'h81);
    applyStimulus(8'h3C, -1, -1, -1);
    waitTxIdle(); settle();
    checkOutput("3c_rx_data", int'(Rx_Data), 8'h3C);
    checkOutput("3c_error", int'(ERROR), 0);

    // Abort after five bits keeps the previous (failed) result
    applyStimulus(8'h77, 6, -1, -1);
    applyStimulus(8'hE1, -1, 5, -1);
    waitTxIdle(); settle();
    checkOutput("abort_rx_data", int'(Rx_Data), 8'h75);
    checkOutput("abort_error", int'(ERROR), 1);
    checkOutput("abort_err_count", int'(Err_Count), 2);
    applyStimulus(8'h4B, -1, -1, -1);
    waitTxIdle(); settle();
    checkOutput("post_abort_rx_data", int'(Rx_Data), 8'h4B);
    checkOutput("post_abort_error", int'(ERROR), 0);

    // Saturation of the error counter
    for (int n = 0; n < 300; n++) begin
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, FRAME_N - 1)), -1, -1);
    end
    waitTxIdle(); settle();
    checkOutput("sat_err_count", int'(Err_Count), 255);
    applyStimulus(8'hC3, -1, -1, -1);
    waitTxIdle(); settle();
    checkOutput("sat_clean_error", int'(ERROR), 0);
    checkOutput("sat_clean_err_count", int'(Err_Count), 255);

    // Random mix of clean, corrupted and aborted frames
    for (int n = 0; n < 60; n++) begin
      int fl;
      int ab;
      repeat ($urandom_range(0, 3)) @(posedge GCLK);
      fl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FRAME_N - 1)) : -1;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, FRAME_N - 1)) : -1;
      applyStimulus(int'($urandom_range(0, 255)), fl, ab, -1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 8)) @(posedge GCLK);
        #1;
        if (txq.size() >= 1) pulseLoadBusy(int'($urandom_range(0, 255)));
      end
    end

    // Asynchronous reset in the CRC phase
    applyStimulus(8'h96, 2, -1, -1);
    k = 0;
    while (txq.size() > 2 && k < 50) begin
      @(posedge GCLK); #1;
      k++;
    end
    #1 CLEAR_BAR = 1'b0;
    txq.delete();
    rxq.delete();
    held_data = 0;
    held_err  = 0;
    held_cnt  = 0;
    err_model = 0;
    cur_flip  = -1;
    cur_abort = -1;
    flip_now  = 1'b0;
    rx_gate   = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(Busy), 0);
    checkOutput("midrst_tx_valid", int'(Tx_Valid), 0);
    checkOutput("midrst_serial_out", int'(Serial_Out), 0);
    checkOutput("midrst_done", int'(Done), 0);
    checkOutput("midrst_error", int'(ERROR), 0);
    checkOutput("midrst_rx_data", int'(Rx_Data), 0);
    checkOutput("midrst_err_count", int'(Err_Count), 0);
    repeat (2) @(posedge GCLK);
    #3 CLEAR_BAR = 1'b1;
    applyStimulus(8'h00, -1, -1, 0);
    waitTxIdle(); settle();
    checkOutput("zero_error", int'(ERROR), 0);
    checkOutput("zero_rx_data", int'(Rx_Data), 0);
    checkOutput("zero_err_count", int'(Err_Count), 0);

    waitTxIdle(); settle();
    checkOutput("rx_frames_outstanding", rxq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
